// File: rtl/core_ctrl_pkg.sv
// Shared definitions for the core pipeline control blocks: hazard FSM states,
// logic level constants and the load-code encoding that drives EX_IS_LOAD.
package core_ctrl_pkg;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_MC_BUSY = 1'b1
    } hz_state_t;

    localparam logic HIGH = 1'b1;
    localparam logic LOW  = 1'b0;

    localparam int                         LOAD_CODE_WIDTH = 3;
    localparam logic [LOAD_CODE_WIDTH-1:0] LOAD_CODE_NONE  = '0;

    // The execution stage derives EX_IS_LOAD from its load code with this helper.
    function automatic logic is_load_code(input logic [LOAD_CODE_WIDTH-1:0] code);
        return (code != LOAD_CODE_NONE);
    endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// Generic event counter used for hazard statistics; wraps by default,
// or holds at all-ones when SATURATE is set.
module hazard_perf_counter #(
    parameter int WIDTH    = 32,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic at_max;

    assign at_max = SATURATE && (&count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && !at_max) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Stall/flush sequencer for the 5-stage core: freeze, multi-cycle ALU, taken branch, load-use.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | no multi-cycle op in flight; branch/load-use resolved here
// ST_MC_BUSY | multi-cycle op holds EX; counter==0 marks the release cycle
module pipeline_hazard_controller
    import core_ctrl_pkg::*;
#(
    parameter int REG_ADD_WIDTH  = 5,
    parameter int MC_LATENCY     = 4,
    parameter int MC_CNT_WIDTH   = 4,
    parameter int PERF_CNT_WIDTH = 32
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic [REG_ADD_WIDTH-1:0] ID_RS1_ADDRESS,
    input  logic [REG_ADD_WIDTH-1:0] ID_RS2_ADDRESS,
    input  logic                     ID_RS1_USED,
    input  logic                     ID_RS2_USED,
    input  logic [REG_ADD_WIDTH-1:0] EX_RD_ADDRESS,
    input  logic                     EX_IS_LOAD,
    input  logic                     EX_MULTI_CYCLE,
    input  logic                     BRANCH_TAKEN,
    input  logic                     MEM_ACCESS,
    input  logic                     DCACHE_READY,
    output logic                     STALL_FETCH_STAGE,
    output logic                     STALL_DECODE_STAGE,
    output logic                     STALL_EXECUTION_STAGE,
    output logic                     STALL_MEMORY_STAGE,
    output logic                     CLEAR_FETCH_STAGE,
    output logic                     CLEAR_DECODE_STAGE,
    output logic                     CLEAR_EXECUTION_STAGE,
    output logic                     MC_BUSY
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0] STALL_CYCLE_COUNT,
    output logic [PERF_CNT_WIDTH-1:0] FLUSH_COUNT
`endif
);

    localparam logic [MC_CNT_WIDTH-1:0] MC_CNT_LOAD = MC_CNT_WIDTH'(MC_LATENCY - 2);

    if (MC_LATENCY < 2 || MC_LATENCY > 16) begin : g_bad_latency
        $error("pipeline_hazard_controller: MC_LATENCY must be 2..16");
    end
    if ((MC_LATENCY - 2) >= (1 << MC_CNT_WIDTH)) begin : g_bad_cnt_width
        $error("pipeline_hazard_controller: MC_CNT_WIDTH too small for MC_LATENCY-2");
    end
    if (PERF_CNT_WIDTH < 1) begin : g_bad_perf_width
        $error("pipeline_hazard_controller: PERF_CNT_WIDTH must be positive");
    end

    hz_state_t                 state;
    hz_state_t                 state_nxt;
    logic [MC_CNT_WIDTH-1:0]   mc_cnt;
    logic [MC_CNT_WIDTH-1:0]   mc_cnt_nxt;
    logic                      freeze;
    logic                      load_use;
    logic                      rs1_hit;
    logic                      rs2_hit;
    logic                      mc_last;

    assign freeze   = MEM_ACCESS & ~DCACHE_READY;
    assign rs1_hit  = ID_RS1_USED & (ID_RS1_ADDRESS == EX_RD_ADDRESS);
    assign rs2_hit  = ID_RS2_USED & (ID_RS2_ADDRESS == EX_RD_ADDRESS);
    assign load_use = EX_IS_LOAD & (EX_RD_ADDRESS != '0) & (rs1_hit | rs2_hit);
    assign mc_last  = (mc_cnt == '0);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state  <= ST_IDLE;
            mc_cnt <= '0;
        end else begin
            state  <= state_nxt;
            mc_cnt <= mc_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        mc_cnt_nxt = mc_cnt;
        if (!freeze) begin
            case (state)
                ST_IDLE: begin
                    if (EX_MULTI_CYCLE) begin
                        state_nxt  = ST_MC_BUSY;
                        mc_cnt_nxt = MC_CNT_LOAD;
                    end
                end
                ST_MC_BUSY: begin
                    // The release cycle returns to IDLE without re-arming on the same op.
                    if (mc_last) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        mc_cnt_nxt = mc_cnt - MC_CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_nxt  = ST_IDLE;
                    mc_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_comb begin
        STALL_FETCH_STAGE     = LOW;
        STALL_DECODE_STAGE    = LOW;
        STALL_EXECUTION_STAGE = LOW;
        STALL_MEMORY_STAGE    = LOW;
        CLEAR_FETCH_STAGE     = LOW;
        CLEAR_DECODE_STAGE    = LOW;
        CLEAR_EXECUTION_STAGE = LOW;
        MC_BUSY               = (state == ST_MC_BUSY);
        if (!RST_N) begin
            // Bubbles are pushed into every clearable register while reset is held.
            CLEAR_FETCH_STAGE     = HIGH;
            CLEAR_DECODE_STAGE    = HIGH;
            CLEAR_EXECUTION_STAGE = HIGH;
        end else if (freeze) begin
            STALL_FETCH_STAGE     = HIGH;
            STALL_DECODE_STAGE    = HIGH;
            STALL_EXECUTION_STAGE = HIGH;
            STALL_MEMORY_STAGE    = HIGH;
        end else if (state == ST_MC_BUSY) begin
            if (!mc_last) begin
                STALL_FETCH_STAGE     = HIGH;
                STALL_DECODE_STAGE    = HIGH;
                CLEAR_EXECUTION_STAGE = HIGH;
            end
        end else if (EX_MULTI_CYCLE) begin
            STALL_FETCH_STAGE     = HIGH;
            STALL_DECODE_STAGE    = HIGH;
            CLEAR_EXECUTION_STAGE = HIGH;
        end else if (BRANCH_TAKEN) begin
            CLEAR_FETCH_STAGE  = HIGH;
            CLEAR_DECODE_STAGE = HIGH;
        end else if (load_use) begin
            STALL_FETCH_STAGE  = HIGH;
            CLEAR_DECODE_STAGE = HIGH;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic branch_flush;

    assign branch_flush = RST_N & ~freeze & (state == ST_IDLE) & ~EX_MULTI_CYCLE & BRANCH_TAKEN;

    hazard_perf_counter #(
        .WIDTH    (PERF_CNT_WIDTH),
        .SATURATE (1'b0)
    ) u_stall_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .inc   (STALL_FETCH_STAGE),
        .count (STALL_CYCLE_COUNT)
    );

    hazard_perf_counter #(
        .WIDTH    (PERF_CNT_WIDTH),
        .SATURATE (1'b0)
    ) u_flush_cnt (
        .clk   (CLK),
        .rst_n (RST_N),
        .inc   (branch_flush),
        .count (FLUSH_COUNT)
    );
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboard bench for pipeline_hazard_controller: directed scenarios then random traffic,
// expected outputs from a cycle-occupancy model pushed to a queue and checked on the falling edge.
module tb_pipeline_hazard_controller;

    localparam int RAW  = 5;
    localparam int LAT  = 4;
    localparam int CNTW = 4;
    localparam int PCW  = 32;

    typedef struct {
        logic           rst_n;
        logic [RAW-1:0] rs1;
        logic [RAW-1:0] rs2;
        logic           rs1_used;
        logic           rs2_used;
        logic [RAW-1:0] rd;
        logic           is_load;
        logic           mc;
        logic           br;
        logic           mem;
        logic           rdy;
    } in_t;

    typedef struct {
        logic [7:0]  outs;
        logic [31:0] stall_cnt;
        logic [31:0] flush_cnt;
        string       tag;
    } exp_t;

    logic           CLK = 1'b0;
    logic           RST_N;
    logic [RAW-1:0] ID_RS1_ADDRESS, ID_RS2_ADDRESS, EX_RD_ADDRESS;
    logic           ID_RS1_USED, ID_RS2_USED, EX_IS_LOAD, EX_MULTI_CYCLE;
    logic           BRANCH_TAKEN, MEM_ACCESS, DCACHE_READY;
    logic           STALL_FETCH_STAGE, STALL_DECODE_STAGE, STALL_EXECUTION_STAGE, STALL_MEMORY_STAGE;
    logic           CLEAR_FETCH_STAGE, CLEAR_DECODE_STAGE, CLEAR_EXECUTION_STAGE, MC_BUSY;
`ifdef HAZARD_PERF_CNT_EN
    logic [PCW-1:0] STALL_CYCLE_COUNT, FLUSH_COUNT;
`endif

    pipeline_hazard_controller #(
        .REG_ADD_WIDTH  (RAW),
        .MC_LATENCY     (LAT),
        .MC_CNT_WIDTH   (CNTW),
        .PERF_CNT_WIDTH (PCW)
    ) dut (
        .CLK                   (CLK),
        .RST_N                 (RST_N),
        .ID_RS1_ADDRESS        (ID_RS1_ADDRESS),
        .ID_RS2_ADDRESS        (ID_RS2_ADDRESS),
        .ID_RS1_USED           (ID_RS1_USED),
        .ID_RS2_USED           (ID_RS2_USED),
        .EX_RD_ADDRESS         (EX_RD_ADDRESS),
        .EX_IS_LOAD            (EX_IS_LOAD),
        .EX_MULTI_CYCLE        (EX_MULTI_CYCLE),
        .BRANCH_TAKEN          (BRANCH_TAKEN),
        .MEM_ACCESS            (MEM_ACCESS),
        .DCACHE_READY          (DCACHE_READY),
        .STALL_FETCH_STAGE     (STALL_FETCH_STAGE),
        .STALL_DECODE_STAGE    (STALL_DECODE_STAGE),
        .STALL_EXECUTION_STAGE (STALL_EXECUTION_STAGE),
        .STALL_MEMORY_STAGE    (STALL_MEMORY_STAGE),
        .CLEAR_FETCH_STAGE     (CLEAR_FETCH_STAGE),
        .CLEAR_DECODE_STAGE    (CLEAR_DECODE_STAGE),
        .CLEAR_EXECUTION_STAGE (CLEAR_EXECUTION_STAGE),
        .MC_BUSY               (MC_BUSY)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .STALL_CYCLE_COUNT     (STALL_CYCLE_COUNT),
        .FLUSH_COUNT           (FLUSH_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    exp_t        sb_q[$];
    int          n_cmp  = 0;
    int          n_fail = 0;

    // Model: cycles of EX occupancy still owed by a multi-cycle op (0 = none in flight).
    int          busy_left = 0;
    logic [31:0] m_stall_cnt = '0;
    logic [31:0] m_flush_cnt = '0;

    // Output vector order: stall F,D,E,M | clear F,D,E | mc_busy
    function automatic in_t idle_in();
        in_t s;
        s.rst_n = 1'b1; s.rs1 = '0; s.rs2 = '0; s.rs1_used = 1'b0; s.rs2_used = 1'b0;
        s.rd = '0; s.is_load = 1'b0; s.mc = 1'b0; s.br = 1'b0; s.mem = 1'b0; s.rdy = 1'b1;
        return s;
    endfunction

    task automatic step(input in_t s, input string tag);
        exp_t e;
        bit   freeze, lu, busy;
        @(posedge CLK);
        #1;
        RST_N          = s.rst_n;
        ID_RS1_ADDRESS = s.rs1;
        ID_RS2_ADDRESS = s.rs2;
        ID_RS1_USED    = s.rs1_used;
        ID_RS2_USED    = s.rs2_used;
        EX_RD_ADDRESS  = s.rd;
        EX_IS_LOAD     = s.is_load;
        EX_MULTI_CYCLE = s.mc;
        BRANCH_TAKEN   = s.br;
        MEM_ACCESS     = s.mem;
        DCACHE_READY   = s.rdy;
        e.tag = tag;
        if (!s.rst_n) begin
            busy_left   = 0;
            m_stall_cnt = '0;
            m_flush_cnt = '0;
            e.outs      = 8'b0000_1110;
        end else begin
            freeze = s.mem && !s.rdy;
            lu     = s.is_load && (s.rd != 0) &&
                     ((s.rs1_used && s.rs1 == s.rd) || (s.rs2_used && s.rs2 == s.rd));
            busy   = (busy_left > 0);
            if (freeze) begin
                e.outs = {4'b1111, 3'b000, busy};
            end else if (busy_left > 1) begin
                e.outs = {4'b1100, 3'b001, 1'b1};
                busy_left--;
            end else if (busy_left == 1) begin
                e.outs = 8'b0000_0001;
                busy_left = 0;
            end else if (s.mc) begin
                e.outs = 8'b1100_0010;
                busy_left = LAT - 1;
            end else if (s.br) begin
                e.outs = 8'b0000_1100;
            end else if (lu) begin
                e.outs = 8'b1000_0100;
            end else begin
                e.outs = 8'b0000_0000;
            end
        end
        e.stall_cnt = m_stall_cnt;
        e.flush_cnt = m_flush_cnt;
        if (s.rst_n) begin
            if (e.outs[7]) m_stall_cnt = m_stall_cnt + 1;
            if (e.outs[3] && e.outs[2]) m_flush_cnt = m_flush_cnt + 1;
        end
        sb_q.push_back(e);
    endtask

    always @(negedge CLK) begin
        exp_t       e;
        logic [7:0] got;
        if (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            got = {STALL_FETCH_STAGE, STALL_DECODE_STAGE, STALL_EXECUTION_STAGE, STALL_MEMORY_STAGE,
                   CLEAR_FETCH_STAGE, CLEAR_DECODE_STAGE, CLEAR_EXECUTION_STAGE, MC_BUSY};
            n_cmp++;
            if (got !== e.outs) begin
                n_fail++;
                $display("FAIL %s: outputs got %b want %b (t=%0t)", e.tag, got, e.outs, $time);
            end
`ifdef HAZARD_PERF_CNT_EN
            n_cmp++;
            if (STALL_CYCLE_COUNT !== e.stall_cnt || FLUSH_COUNT !== e.flush_cnt) begin
                n_fail++;
                $display("FAIL %s_perf: stall/flush got %0d/%0d want %0d/%0d", e.tag,
                         STALL_CYCLE_COUNT, FLUSH_COUNT, e.stall_cnt, e.flush_cnt);
            end
`endif
        end
    end

    initial begin
        in_t s;
        RST_N = 1'b0;
        s = idle_in();
        ID_RS1_ADDRESS = '0; ID_RS2_ADDRESS = '0; EX_RD_ADDRESS = '0;
        ID_RS1_USED = 1'b0; ID_RS2_USED = 1'b0; EX_IS_LOAD = 1'b0; EX_MULTI_CYCLE = 1'b0;
        BRANCH_TAKEN = 1'b0; MEM_ACCESS = 1'b0; DCACHE_READY = 1'b1;

        s.rst_n = 1'b0;
        step(s, "reset0");
        s.mc = 1'b1; s.br = 1'b1;
        step(s, "reset_inputs_ignored");
        s = idle_in();
        step(s, "idle");

        // load-use on rs1, then resolved, then x0 destination
        s = idle_in(); s.is_load = 1'b1; s.rd = 5'd5; s.rs1 = 5'd5; s.rs1_used = 1'b1;
        step(s, "load_use_rs1");
        s = idle_in();
        step(s, "load_use_gone");
        s = idle_in(); s.is_load = 1'b1; s.rd = 5'd0; s.rs1 = 5'd0; s.rs1_used = 1'b1;
        step(s, "load_use_x0");
        s = idle_in(); s.is_load = 1'b1; s.rd = 5'd9; s.rs2 = 5'd9; s.rs2_used = 1'b0;
        step(s, "load_rs2_unused");
        s.rs2_used = 1'b1;
        step(s, "load_use_rs2");

        // multi-cycle op with EX_MULTI_CYCLE held through the release cycle
        s = idle_in(); s.mc = 1'b1;
        for (int i = 0; i < LAT; i++) step(s, $sformatf("mc_cycle%0d", i + 1));
        s = idle_in();
        step(s, "mc_done");

        // taken branch while a load-use also applies
        s = idle_in(); s.br = 1'b1; s.is_load = 1'b1; s.rd = 5'd3; s.rs1 = 5'd3; s.rs1_used = 1'b1;
        step(s, "branch_over_load_use");

        // freeze during MC_BUSY with the counter at 1
        s = idle_in(); s.mc = 1'b1;
        step(s, "mcf_start");
        step(s, "mcf_busy");
        s.mem = 1'b1; s.rdy = 1'b0; s.br = 1'b1;
        for (int i = 0; i < 3; i++) step(s, $sformatf("mcf_freeze%0d", i));
        s.rdy = 1'b1; s.br = 1'b0;
        step(s, "mcf_after_freeze");
        step(s, "mcf_release");
        s = idle_in();
        step(s, "mcf_idle");

        // freeze while idle suppresses a branch and a multi-cycle start
        s = idle_in(); s.mem = 1'b1; s.rdy = 1'b0; s.br = 1'b1; s.mc = 1'b1;
        step(s, "freeze_idle");
        s = idle_in();
        step(s, "freeze_idle_after");

        // reset asserted mid multi-cycle op
        s = idle_in(); s.mc = 1'b1;
        step(s, "mcr_start");
        step(s, "mcr_busy");
        s.rst_n = 1'b0;
        step(s, "mcr_reset");
        s = idle_in();
        step(s, "mcr_after_reset");

        for (int i = 0; i < 600; i++) begin
            s.rst_n    = ($urandom_range(0, 99) != 0);
            s.rs1      = RAW'($urandom_range(0, 3));
            s.rs2      = RAW'($urandom_range(0, 3));
            s.rd       = RAW'($urandom_range(0, 3));
            s.rs1_used = 1'($urandom_range(0, 1));
            s.rs2_used = 1'($urandom_range(0, 1));
            s.is_load  = ($urandom_range(0, 2) == 0);
            s.mc       = ($urandom_range(0, 9) == 0);
            s.br       = ($urandom_range(0, 5) == 0);
            s.mem      = 1'($urandom_range(0, 1));
            s.rdy      = ($urandom_range(0, 3) != 0);
            step(s, $sformatf("rand%0d", i));
        end

        s = idle_in();
        step(s, "final_idle");
        @(posedge CLK);
        @(posedge CLK);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: pending %0d want 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
